// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access formats, FSM states and
// format decode helpers.
package lsu_pkg;

  localparam logic [2:0] FMT_B  = 3'b000;
  localparam logic [2:0] FMT_H  = 3'b001;
  localparam logic [2:0] FMT_W  = 3'b010;
  localparam logic [2:0] FMT_BU = 3'b100;
  localparam logic [2:0] FMT_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  // Access size in bytes; illegal encodings report 4 but are rejected anyway.
  function automatic logic [2:0] fmt_size(input logic [2:0] fmt);
    case (fmt[1:0])
      2'b00:   fmt_size = 3'd1;
      2'b01:   fmt_size = 3'd2;
      default: fmt_size = 3'd4;
    endcase
  endfunction

  function automatic logic fmt_illegal(input logic [2:0] fmt, input logic we);
    fmt_illegal = (fmt == 3'b011) || (fmt == 3'b110) || (fmt == 3'b111) ||
                  (we && fmt[2]);
  endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load result extension: sign-extend b/h, zero-extend bu/hu, pass w through.
module lsu_extend
  import lsu_pkg::*;
(
  input  logic [2:0]  fmt,
  input  logic [31:0] data,
  output logic [31:0] ext
);

  always_comb begin
    case (fmt)
      FMT_B:   ext = {{24{data[7]}}, data[7:0]};
      FMT_H:   ext = {{16{data[15]}}, data[15:0]};
      FMT_BU:  ext = {24'h0, data[7:0]};
      FMT_HU:  ext = {16'h0, data[15:0]};
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one request per handshake, aligned single-beat access or
// misaligned byte-beat split with reassembly, one response per request.
module lsu
  import lsu_pkg::*;
#(
  parameter int SIZE = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_fmt,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_w_data,
  output logic [2:0]  o_mem_fmt,
  output logic        o_mem_r_en,
  output logic        o_mem_w_en,
  input  logic [31:0] i_mem_r_data
);

  state_t      state, state_nxt;
  logic        we_q, err_q;
  logic [2:0]  fmt_q;
  logic [31:0] addr_q, wdata_q, buf_q;
  logic [1:0]  k_q, last_q;

  logic [2:0]  req_size;
  logic [32:0] req_end;
  logic        req_err, req_mis, accept, last_beat, mis_q;
  logic [1:0]  req_last;
  logic [31:0] ext_data;

  // Bounds check in 33 bits so an address near 2^32 cannot wrap into range.
  assign req_size  = fmt_size(i_req_fmt);
  assign req_end   = {1'b0, i_req_addr} + {30'b0, req_size} - 33'd1;
  assign req_err   = fmt_illegal(i_req_fmt, i_req_we) || (req_end >= 33'(SIZE));
  assign req_mis   = ((req_size == 3'd2) && i_req_addr[0]) ||
                     ((req_size == 3'd4) && (i_req_addr[1:0] != 2'b00));
  assign req_last  = req_mis ? 2'(req_size - 3'd1) : 2'd0;

  assign o_req_ready = i_rst_n && (state == IDLE);
  assign accept      = i_req_valid && o_req_ready;
  assign last_beat   = (k_q == last_q);
  assign mis_q       = (last_q != 2'd0);

  lsu_extend u_ext (
    .fmt  (fmt_q),
    .data (buf_q),
    .ext  (ext_data)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    o_rsp_valid  = 1'b0;
    o_rsp_rdata  = 32'h0;
    o_rsp_err    = 1'b0;
    o_mem_addr   = 32'h0;
    o_mem_w_data = 32'h0;
    o_mem_fmt    = FMT_B;
    o_mem_r_en   = 1'b0;
    o_mem_w_en   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = req_err ? RESP : ACCESS;
      end
      ACCESS: begin
        o_mem_r_en = !we_q;
        o_mem_w_en = we_q;
        if (mis_q) begin
          o_mem_addr   = addr_q + {30'b0, k_q};
          o_mem_w_data = {24'h0, wdata_q[{k_q, 3'b000} +: 8]};
        end else begin
          o_mem_addr   = addr_q;
          o_mem_fmt    = {1'b0, fmt_q[1:0]};
          o_mem_w_data = wdata_q;
        end
        if (last_beat) state_nxt = RESP;
      end
      RESP: begin
        o_rsp_valid = 1'b1;
        o_rsp_err   = err_q;
        o_rsp_rdata = (we_q || err_q) ? 32'h0 : ext_data;
        if (i_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      fmt_q   <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      buf_q   <= 32'h0;
      k_q     <= 2'd0;
      last_q  <= 2'd0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            we_q    <= i_req_we;
            fmt_q   <= i_req_fmt;
            addr_q  <= i_req_addr;
            wdata_q <= i_req_wdata;
            err_q   <= req_err;
            last_q  <= req_last;
            k_q     <= 2'd0;
            buf_q   <= 32'h0;
          end
        end
        ACCESS: begin
          if (!we_q) begin
            if (mis_q) buf_q[{k_q, 3'b000} +: 8] <= i_mem_r_data[7:0];
            else       buf_q <= i_mem_r_data;
          end
          k_q <= last_beat ? 2'd0 : k_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and `dmem`. Accepts one load or store per valid/ready handshake, checks format and bounds, and drives the `dmem` port. Aligned accesses complete in one memory beat. Misaligned accesses are split into sequential byte beats and reassembled. Each request returns exactly one response carrying load data or an error flag.

## Interface
- `SIZE`, default 1024: bytes in the attached `dmem`; must match its `SIZE`.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous, active-low.
- `i_req_valid`  in  1  request present.
- `o_req_ready`  out  1  LSU can accept a request.
- `i_req_we`  in  1  1 = store, 0 = load.
- `i_req_fmt`  in  3  funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- `i_req_addr`  in  32  byte address.
- `i_req_wdata`  in  32  store data, right-aligned.
- `o_rsp_valid`  out  1  response present.
- `i_rsp_ready`  in  1  consumer takes the response.
- `o_rsp_rdata`  out  32  load result, extended per fmt; 0 for stores and errors.
- `o_rsp_err`  out  1  illegal fmt or out-of-range access.
- `o_mem_addr`  out  32  to `dmem` `i_addr`.
- `o_mem_w_data`  out  32  to `dmem` `i_w_data`.
- `o_mem_fmt`  out  3  to `dmem` `i_fmt`.
- `o_mem_r_en`  out  1  to `dmem` `i_r_en`.
- `o_mem_w_en`  out  1  to `dmem` `i_w_en`.
- `i_mem_r_data`  in  32  from `dmem` `o_r_data`, combinational.

## Operation
- States:
  - IDLE: `o_req_ready`=1.
  - ACCESS: one memory beat per cycle.
  - RESP: `o_rsp_valid`=1.
- IDLE, on `i_req_valid`&`o_req_ready`:
  - Latch we, fmt, addr, wdata.
  - Compute size S: 1 for b/bu, 2 for h/hu, 4 for w.
  - Error if fmt ∈ {011,110,111}, or we=1 with fmt ∈ {100,101}, or addr+S-1 ≥ SIZE. Compute in 33 bits so the sum cannot wrap.
  - On error: go to RESP with err=1, rdata=0, no memory enable ever asserted.
  - Otherwise: misaligned = (S=2 & addr[0]) | (S=4 & addr[1:0]≠0). Beats B = misaligned ? S : 1. Clear the beat counter k; go to ACCESS.
- ACCESS, aligned (B=1):
  - `o_mem_addr`=addr, `o_mem_fmt`={1'b0,fmt[1:0]}, `o_mem_w_data`=wdata.
  - Load: capture `i_mem_r_data` at the edge.
- ACCESS, misaligned beat k:
  - `o_mem_addr`=addr+k, `o_mem_fmt`=000, `o_mem_w_data`={24'b0, wdata[8k+:8]}.
  - Load: capture `i_mem_r_data[7:0]` into buffer byte k.
- In ACCESS, `o_mem_r_en`=!we and `o_mem_w_en`=we. After beat B-1, go to RESP.
- RESP:
  - Load rdata: sign-extend byte/half for b/h, zero-extend for bu/hu, pass w unchanged.
  - Hold rdata/err stable until `i_rsp_ready`, then go to IDLE.
  - Stores respond with rdata=0, err=0.
- Outside ACCESS: memory enables=0, `o_mem_addr`/`o_mem_w_data`=0, `o_mem_fmt`=000.

## Timing
- Reset: state IDLE, k=0, all latched fields 0.
- Outputs during reset: `o_req_ready`=0 (gated by `i_rst_n`), `o_rsp_valid`=0, `o_rsp_rdata`=0, `o_rsp_err`=0, memory enables 0.
- Accept at edge N:
  - ACCESS cycles N+1..N+B.
  - `o_rsp_valid` high from cycle N+B+1.
  - Aligned: response 2 cycles after accept. Misaligned word: 5 cycles. Error: 1 cycle.
- Request and response never overlap: the next accept is no earlier than the cycle after the response handshake. Peak throughput is one aligned op per 3 cycles.
- `o_rsp_valid` with `i_rsp_ready`=0: hold indefinitely, all response outputs stable.
- Reset asserted mid-ACCESS: enables drop immediately (async). Bytes of a misaligned store already written stay written; no response is produced.
- Address arithmetic is 32-bit. Bounds are checked before any beat, so addr+k never wraps in ACCESS.

## Structure
- `lsu_pkg` holds:
  - Fmt constants: FMT_B=3'b000, FMT_H=3'b001, FMT_W=3'b010, FMT_BU=3'b100, FMT_HU=3'b101.
  - State enum: IDLE, ACCESS, RESP.
  - Size-decode function.
- One sub-module, `lsu_extend`: combinational byte/half sign/zero extension keyed by fmt.
- FSM, beat counter and byte assembly buffer live in `lsu`.

## Test plan
- Aligned store word 0xDEADBEEF at addr 0x10, then load w at 0x10:
  - Store responds in cycle N+2 with err=0.
  - Load returns 0xDEADBEEF.
  - lb at 0x13 returns 0xFFFFFFDE; lbu at 0x13 returns 0x000000DE.
- Misaligned store word 0x11223344 at addr 0x21:
  - Exactly 4 byte-write beats at 0x21..0x24 with data 44,33,22,11.
  - Load w at 0x21 returns 0x11223344 after 4 beats, response at N+5.
- lh at 0x41 after storing bytes 0x80 at 0x41 and 0x7F at 0x42:
  - 2 beats, rdata 0x00007F80.
  - Repeat with 0xFF at 0x42: lh returns 0xFFFFFF80, lhu returns 0x0000FF80.
- Errors, each responding at N+1 with err=1, rdata=0, and no enable ever high:
  - fmt=011.
  - Store with fmt=100.
  - lw at SIZE-2.
- Response backpressure: hold `i_rsp_ready`=0 for 5 cycles.
  - rdata and err stay stable; `o_req_ready` stays 0.
  - Next request is accepted one cycle after the handshake.
- Assert `i_rst_n`=0 during beat 2 of a misaligned word store:
  - Enables drop the same cycle.
  - After release: state IDLE, `o_rsp_valid`=0, bytes 0 and 1 written, bytes 2 and 3 unchanged.
